// File: rtl/decode_basic.sv
// decode_basic: RV32I integer-subset decode stage.
// Takes instruction/PC pairs from fetch and reads a 32x32 register file.
// A one-bit-per-register scoreboard stalls decode on register hazards.
// JAL redirects fetch in the cycle it is accepted.
// Decoded micro-ops are held in a single D/X register until execute takes them.
module decode_basic #(
  parameter int p_addr_bits = 32,
  parameter int p_inst_bits = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   f_val,
  output logic                   f_rdy,
  input  logic [p_inst_bits-1:0] f_inst,
  input  logic [p_addr_bits-1:0] f_pc,
  output logic                   f_squash,
  output logic                   f_branch_val,
  output logic [p_addr_bits-1:0] f_branch_target,
  output logic                   x_val,
  input  logic                   x_rdy,
  output logic [p_addr_bits-1:0] x_pc,
  output logic [3:0]             x_uop,
  output logic [31:0]            x_op1,
  output logic [31:0]            x_op2,
  output logic [4:0]             x_waddr,
  output logic                   x_wen,
  input  logic                   w_val,
  input  logic [4:0]             w_addr,
  input  logic [31:0]            w_data
);

  localparam logic [3:0] lp_uop_add  = 4'd0;
  localparam logic [3:0] lp_uop_sub  = 4'd1;
  localparam logic [3:0] lp_uop_and  = 4'd2;
  localparam logic [3:0] lp_uop_or   = 4'd3;
  localparam logic [3:0] lp_uop_xor  = 4'd4;
  localparam logic [3:0] lp_uop_slt  = 4'd5;
  localparam logic [3:0] lp_uop_sltu = 4'd6;
  localparam logic [3:0] lp_uop_cp   = 4'd7;
  localparam logic [3:0] lp_uop_ill  = 4'd15;

  localparam logic [6:0] lp_op_r     = 7'h33;
  localparam logic [6:0] lp_op_i     = 7'h13;
  localparam logic [6:0] lp_op_lui   = 7'h37;
  localparam logic [6:0] lp_op_auipc = 7'h17;
  localparam logic [6:0] lp_op_jal   = 7'h6f;

  logic [31:0]            r_rf [32];
  logic [31:0]            r_pending;
  logic                   r_x_val;
  logic [p_addr_bits-1:0] r_x_pc;
  logic [3:0]             r_x_uop;
  logic [31:0]            r_x_op1;
  logic [31:0]            r_x_op2;
  logic [4:0]             r_x_waddr;
  logic                   r_x_wen;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [31:0] w_pc32;
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;
  logic [3:0]  w_uop;
  logic [31:0] w_op1;
  logic [31:0] w_op2;
  logic        w_wen;
  logic        w_use1;
  logic        w_use2;
  logic        w_jal;
  logic        w_legal;
  logic [31:0] w_clr;
  logic [31:0] w_set;
  logic [31:0] w_pend_eff;
  logic        w_hazard;
  logic        w_xfer;

  assign w_opcode = f_inst[6:0];
  assign w_rd     = f_inst[11:7];
  assign w_funct3 = f_inst[14:12];
  assign w_rs1    = f_inst[19:15];
  assign w_rs2    = f_inst[24:20];
  assign w_funct7 = f_inst[31:25];
  assign w_imm_i  = {{20{f_inst[31]}}, f_inst[31:20]};
  assign w_imm_u  = {f_inst[31:12], 12'b0};
  assign w_imm_j  = {{11{f_inst[31]}}, f_inst[31], f_inst[19:12], f_inst[20], f_inst[30:21], 1'b0};
  assign w_pc32   = 32'(f_pc);

  // register file read ports; a same-cycle writeback to the read register is forwarded
  always_comb begin
    w_rs1_data = '0;
    w_rs2_data = '0;
    if (w_rs1 != 5'd0) w_rs1_data = (w_val && w_addr == w_rs1) ? w_data : r_rf[w_rs1];
    if (w_rs2 != 5'd0) w_rs2_data = (w_val && w_addr == w_rs2) ? w_data : r_rf[w_rs2];
  end

  // instruction decode into uop, operands and register usage
  always_comb begin
    w_uop   = lp_uop_ill;
    w_op1   = '0;
    w_op2   = '0;
    w_wen   = 1'b0;
    w_use1  = 1'b0;
    w_use2  = 1'b0;
    w_jal   = 1'b0;
    w_legal = 1'b0;
    case (w_opcode)
      lp_op_r: begin
        w_legal = 1'b1;
        w_use1  = 1'b1;
        w_use2  = 1'b1;
        w_op1   = w_rs1_data;
        w_op2   = w_rs2_data;
        case ({w_funct7, w_funct3})
          {7'h00, 3'b000}: w_uop = lp_uop_add;
          {7'h20, 3'b000}: w_uop = lp_uop_sub;
          {7'h00, 3'b111}: w_uop = lp_uop_and;
          {7'h00, 3'b110}: w_uop = lp_uop_or;
          {7'h00, 3'b100}: w_uop = lp_uop_xor;
          {7'h00, 3'b010}: w_uop = lp_uop_slt;
          {7'h00, 3'b011}: w_uop = lp_uop_sltu;
          default:         w_legal = 1'b0;
        endcase
      end
      lp_op_i: begin
        w_legal = 1'b1;
        w_use1  = 1'b1;
        w_op1   = w_rs1_data;
        w_op2   = w_imm_i;
        case (w_funct3)
          3'b000:  w_uop = lp_uop_add;
          3'b010:  w_uop = lp_uop_slt;
          3'b011:  w_uop = lp_uop_sltu;
          3'b100:  w_uop = lp_uop_xor;
          3'b110:  w_uop = lp_uop_or;
          3'b111:  w_uop = lp_uop_and;
          default: w_legal = 1'b0;
        endcase
      end
      lp_op_lui: begin
        w_legal = 1'b1;
        w_uop   = lp_uop_cp;
        w_op2   = w_imm_u;
      end
      lp_op_auipc: begin
        w_legal = 1'b1;
        w_uop   = lp_uop_add;
        w_op1   = w_pc32;
        w_op2   = w_imm_u;
      end
      lp_op_jal: begin
        w_legal = 1'b1;
        w_uop   = lp_uop_add;
        w_op1   = w_pc32;
        w_op2   = 32'd4;
        w_jal   = 1'b1;
      end
      default: ;
    endcase
    if (w_legal) begin
      w_wen = 1'b1;
    end else begin
      // illegal words still flow to execute but read nothing and write nothing
      w_uop  = lp_uop_ill;
      w_op1  = '0;
      w_op2  = '0;
      w_use1 = 1'b0;
      w_use2 = 1'b0;
      w_jal  = 1'b0;
    end
  end

  // a register being written back this cycle no longer counts as pending
  assign w_clr      = w_val ? (32'd1 << w_addr) : '0;
  assign w_pend_eff = r_pending & ~w_clr;
  assign w_hazard   = (w_use1 && w_pend_eff[w_rs1]) ||
                      (w_use2 && w_pend_eff[w_rs2]) ||
                      (w_wen  && w_pend_eff[w_rd]);
  assign f_rdy      = !w_hazard && (!r_x_val || x_rdy);
  assign w_xfer     = f_val && f_rdy;
  assign w_set      = (w_xfer && w_wen) ? (32'd1 << w_rd) : '0;

  assign f_branch_val    = w_xfer && w_jal;
  assign f_squash        = w_xfer && w_jal;
  assign f_branch_target = (w_xfer && w_jal) ? (f_pc + p_addr_bits'(w_imm_j)) : '0;

  // scoreboard update; a set on accept overrides a clear from writeback, x0 never pends
  always_ff @(posedge clk) begin
    if (rst) r_pending <= '0;
    else     r_pending <= ((r_pending & ~w_clr) | w_set) & 32'hFFFF_FFFE;
  end

  // register file write port; x0 stays zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (w_val && w_addr != 5'd0) begin
      r_rf[w_addr] <= w_data;
    end
  end

  // D/X pipeline register: load on transfer, drain when execute takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x_val   <= 1'b0;
      r_x_pc    <= '0;
      r_x_uop   <= '0;
      r_x_op1   <= '0;
      r_x_op2   <= '0;
      r_x_waddr <= '0;
      r_x_wen   <= 1'b0;
    end else if (w_xfer) begin
      r_x_val   <= 1'b1;
      r_x_pc    <= f_pc;
      r_x_uop   <= w_uop;
      r_x_op1   <= w_op1;
      r_x_op2   <= w_op2;
      r_x_waddr <= w_rd;
      r_x_wen   <= w_wen;
    end else if (r_x_val && x_rdy) begin
      r_x_val   <= 1'b0;
    end
  end

  assign x_val   = r_x_val;
  assign x_pc    = r_x_pc;
  assign x_uop   = r_x_uop;
  assign x_op1   = r_x_op1;
  assign x_op2   = r_x_op2;
  assign x_waddr = r_x_waddr;
  assign x_wen   = r_x_wen;

endmodule
